mult_arbiter: RTL and testbench
===============================

# mult_arbiter

Sequencer and two-port arbiter for the 8-bit shift-add (Booth radix-2) multiplier datapath: A/B shift registers, X and Q-1 flip-flops, and the 9-bit adder/subtractor. It accepts multiply requests from two clients and arbitrates between them round-robin. It latches the winner's operands and drives the datapath's load, clear, add, subtract and shift strobes for eight Booth iterations. It then captures the 16-bit signed product and returns it with a one-cycle done pulse.

## Interface
- No parameters; operand width fixed at 8, iteration count fixed at 8.
- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-high; forces every output and internal register to its reset value.
- Req0, Req1  in  1  request from client 0/1; level, held until Done of that client or withdrawn while idle.
- Mcand0, Mcand1  in  8  signed multiplicand of client 0/1; sampled on the grant edge only.
- Mplier0, Mplier1  in  8  signed multiplier of client 0/1; sampled on the grant edge only.
- M  in  1  datapath B[0].
- Qm1  in  1  datapath Q-1 bit.
- Aval, Bval  in  8  datapath A and B register contents.
- Grant0, Grant1  out  1  one-hot grant, high from grant edge through the DONE state; reset 0.
- Done0, Done1  out  1  one-cycle pulse, product valid for that client; reset 0.
- Product  out  16  signed product {Aval,Bval}; holds until next capture; reset 0.
- LoadB  out  1  load B from Mplier and clear A, X, Q-1; reset 0.
- Add, Sub  out  1  load A/X from adder in add or subtract mode; mutually exclusive; reset 0.
- Fn  out  1  adder mode, equals Sub; reset 0.
- Shift  out  1  arithmetic right shift of X:A:B:Q-1; reset 0.
- McandOut, MplierOut  out  8  latched operands to adder B input and B register D input; reset 0.

## Operation
- States: IDLE, LOAD, EVAL, SHIFT, CAPTURE, DONE. Iteration counter 3 bits, cleared in LOAD.
- IDLE: if any Req is high, grant per round-robin pointer.
  - Set the Grant bit and latch the winner's Mcand/Mplier into McandOut/MplierOut.
  - Go to LOAD. With no request, remain in IDLE and hold all strobes at 0.
- Arbitration:
  - The pointer names the preferred client; reset value 0.
  - Only one Req high: grant it regardless of pointer.
  - Both high: grant the preferred client.
  - After each grant, the pointer moves to the other client.
- LOAD: LoadB=1 for one cycle, then go to EVAL.
- EVAL: decode {M,Qm1}.
  - 10 gives Sub=1, Fn=1.
  - 01 gives Add=1.
  - 00 and 11 give no strobe.
  - Then go to SHIFT.
- SHIFT: Shift=1 and counter increments. Counter 7 before increment goes to CAPTURE; otherwise return to EVAL.
- CAPTURE: Product <= {Aval,Bval} on exit edge; go to DONE.
- DONE: Done bit of the granted client = 1. On exit, clear Grant and return to IDLE.
- A request withdrawn mid-operation does not abort; the sequence completes and Done still pulses.
- Operand inputs may change freely once Grant is high.
- Strobes LoadB, Add, Sub and Shift are never high simultaneously.

## Timing
- All outputs are registered or decoded from state only; there is no combinational Req-to-output path.
- Req is sampled at edge k in IDLE. Relative to that edge:
  - Grant and operands are valid after edge k.
  - LOAD is cycle 1.
  - EVAL i is cycle 2+2i and SHIFT i is cycle 3+2i, for i = 0..7.
  - CAPTURE is cycle 18 and DONE is cycle 19.
- Done is high from edge k+18 to k+19; Product is valid from edge k+18.
- IDLE occupies at least one cycle between operations. A client still holding Req at the end of that IDLE cycle is eligible again; the other client wins if it is also requesting.
- Reset asserted at any point: outputs go to 0 immediately, state goes to IDLE, pointer to 0, and no Done is produced for the aborted operation.
- After Reset deasserts, the first possible grant is the first rising edge with Reset low.

## Test plan
- Bench couples this block to a behavioral model of the datapath: 9-bit X:A, B, Q-1, arithmetic shift.
- Req0 with Mcand0=7, Mplier0=-3 (0xFD) -> Grant0 after edge k; Done0 pulse in cycle 19; Product=0xFFEB. Grant1 stays 0 throughout.
- Req1 with Mcand1=0x80, Mplier1=0x80 -> Product=0x4000 with Done1. Mplier1=0x00 -> 8 Shift pulses, zero Add/Sub pulses, Product=0x0000.
- Req0 and Req1 rise in the same cycle after reset:
  - Client 0 is served first.
  - Client 1 is granted at the first IDLE after Done0.
  - Both requests then held continuously -> grants alternate 0,1,0.
- Req0 high throughout, Mcand0=3, Mplier0=5 -> back-to-back products 0x000F. Exactly one IDLE cycle separates Done0 from the next LoadB.
- Reset pulsed at cycle 10 of an operation -> all outputs 0 at once; no Done pulse. A new Req0 (2 x 2) then yields Product=0x0004 with standard 19-cycle latency.

Source files
------------

// File: rtl/mult_arbiter.sv
// Round-robin two-client sequencer for an 8-bit Booth radix-2 shift-add multiplier datapath.
// Latches the winning client's operands, strobes eight EVAL/SHIFT iterations and returns the 16-bit product.
module mult_arbiter (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req0,
    input  logic        Req1,
    input  logic [7:0]  Mcand0,
    input  logic [7:0]  Mcand1,
    input  logic [7:0]  Mplier0,
    input  logic [7:0]  Mplier1,
    input  logic        M,
    input  logic        Qm1,
    input  logic [7:0]  Aval,
    input  logic [7:0]  Bval,
    output logic        Grant0,
    output logic        Grant1,
    output logic        Done0,
    output logic        Done1,
    output logic [15:0] Product,
    output logic        LoadB,
    output logic        Add,
    output logic        Sub,
    output logic        Fn,
    output logic        Shift,
    output logic [7:0]  McandOut,
    output logic [7:0]  MplierOut
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EVAL,
        S_SHIFT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_cnt;
    logic        r_ptr;
    logic        r_grant0;
    logic        r_grant1;
    logic [7:0]  r_mcand;
    logic [7:0]  r_mplier;
    logic [15:0] r_product;
    logic        w_any;
    logic        w_pick1;

    // Client 1 wins when it is the only requester, or both request and the pointer prefers it.
    always_comb begin
        w_any   = Req0 | Req1;
        w_pick1 = Req1 & (~Req0 | r_ptr);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        LoadB  = 1'b0;
        Add    = 1'b0;
        Sub    = 1'b0;
        Shift  = 1'b0;
        case (r_state)
            S_IDLE:    if (w_any) w_next = S_LOAD;
            S_LOAD: begin
                LoadB  = 1'b1;
                w_next = S_EVAL;
            end
            S_EVAL: begin
                Add    = ~M & Qm1;
                Sub    = M & ~Qm1;
                w_next = S_SHIFT;
            end
            S_SHIFT: begin
                Shift  = 1'b1;
                w_next = (r_cnt == 3'd7) ? S_CAPTURE : S_EVAL;
            end
            S_CAPTURE: w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_cnt     <= '0;
            r_ptr     <= 1'b0;
            r_grant0  <= 1'b0;
            r_grant1  <= 1'b0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant0 <= ~w_pick1;
                        r_grant1 <= w_pick1;
                        r_ptr    <= ~w_pick1;
                        r_mcand  <= w_pick1 ? Mcand1 : Mcand0;
                        r_mplier <= w_pick1 ? Mplier1 : Mplier0;
                    end
                end
                S_LOAD:    r_cnt     <= '0;
                S_SHIFT:   r_cnt     <= r_cnt + 3'd1;
                S_CAPTURE: r_product <= {Aval, Bval};
                S_DONE: begin
                    r_grant0 <= 1'b0;
                    r_grant1 <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign Grant0    = r_grant0;
    assign Grant1    = r_grant1;
    assign Done0     = (r_state == S_DONE) & r_grant0;
    assign Done1     = (r_state == S_DONE) & r_grant1;
    assign Fn        = Sub;
    assign Product   = r_product;
    assign McandOut  = r_mcand;
    assign MplierOut = r_mplier;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: behavioral Booth datapath model plus directed vectors with hand-computed products.
module tb_mult_arbiter;

    logic        Clk;
    logic        Reset;
    logic        Req0, Req1;
    logic [7:0]  Mcand0, Mcand1, Mplier0, Mplier1;
    logic        M, Qm1;
    logic [7:0]  Aval, Bval;
    logic        Grant0, Grant1, Done0, Done1;
    logic [15:0] Product;
    logic        LoadB, Add, Sub, Fn, Shift;
    logic [7:0]  McandOut, MplierOut;

    int n_cmp  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int ndone  = 0;
    int done_cyc = 0;

    mult_arbiter dut (
        .Clk(Clk), .Reset(Reset), .Req0(Req0), .Req1(Req1),
        .Mcand0(Mcand0), .Mcand1(Mcand1), .Mplier0(Mplier0), .Mplier1(Mplier1),
        .M(M), .Qm1(Qm1), .Aval(Aval), .Bval(Bval),
        .Grant0(Grant0), .Grant1(Grant1), .Done0(Done0), .Done1(Done1),
        .Product(Product), .LoadB(LoadB), .Add(Add), .Sub(Sub), .Fn(Fn), .Shift(Shift),
        .McandOut(McandOut), .MplierOut(MplierOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Datapath model: 9-bit X:A accumulator, B register, Q-1 flop.
    logic [8:0] dp_xa;
    logic [7:0] dp_b;
    logic       dp_q;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            dp_xa <= '0;
            dp_b  <= '0;
            dp_q  <= 1'b0;
        end else if (LoadB) begin
            dp_xa <= '0;
            dp_b  <= MplierOut;
            dp_q  <= 1'b0;
        end else if (Add) begin
            dp_xa <= {dp_xa[7], dp_xa[7:0]} + {McandOut[7], McandOut};
        end else if (Sub) begin
            dp_xa <= {dp_xa[7], dp_xa[7:0]} - {McandOut[7], McandOut};
        end else if (Shift) begin
            dp_xa <= {dp_xa[8], dp_xa[8:1]};
            dp_b  <= {dp_xa[0], dp_b[7:1]};
            dp_q  <= dp_b[0];
        end
    end

    assign Aval = dp_xa[7:0];
    assign Bval = dp_b;
    assign M    = dp_b[0];
    assign Qm1  = dp_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge Clk) cyc++;

    always @(negedge Clk) begin
        if (!Reset) begin
            check("strobe_excl", 32'($countones({LoadB, Add, Sub, Shift}) <= 1), 1);
            check("fn_eq_sub", Fn, Sub);
            check("grant_onehot", Grant0 & Grant1, 0);
            if (Done0 | Done1) ndone++;
        end
    end

    // Single operation for one client; caller is at a negedge with the DUT idle.
    task automatic do_op(input int c, input logic [7:0] mc, input logic [7:0] mp,
                         input logic [15:0] prod, input int n_as);
        int   n_sh;
        int   n_ad;
        logic other;
        logic g;
        logic d;
        n_sh = 0;
        n_ad = 0;
        other = 1'b0;
        if (c == 0) begin Req0 = 1'b1; Mcand0 = mc; Mplier0 = mp; end
        else        begin Req1 = 1'b1; Mcand1 = mc; Mplier1 = mp; end
        @(posedge Clk);
        for (int n = 1; n <= 20; n++) begin
            @(negedge Clk);
            g = (c == 0) ? Grant0 : Grant1;
            d = (c == 0) ? Done0 : Done1;
            other = other | ((c == 0) ? (Grant1 | Done1) : (Grant0 | Done0));
            if (n == 1) begin
                check("grant", g, 1);
                check("loadb", LoadB, 1);
                check("mcand_out", McandOut, mc);
                check("mplier_out", MplierOut, mp);
                Mcand0 = 8'hA5; Mplier0 = 8'h5A; Mcand1 = 8'h3C; Mplier1 = 8'hC3;
            end
            n_sh += int'(Shift);
            n_ad += int'(Add | Sub);
            if (n == 18) check("done_early", d, 0);
            if (n == 19) begin
                check("done", d, 1);
                check("product", Product, prod);
                if (c == 0) Req0 = 1'b0; else Req1 = 1'b0;
            end
            if (n == 20) begin
                check("done_clear", d, 0);
                check("grant_clear", g, 0);
                check("product_hold", Product, prod);
            end
        end
        check("shift_count", n_sh, 8);
        check("addsub_count", n_ad, n_as);
        check("other_client", other, 0);
    endtask

    // Wait for the next grant and its Done with requests left to the caller.
    task automatic serve(input int c, input logic [15:0] prod, input bit chk_gap);
        int t;
        t = 0;
        while (!LoadB && t < 40) begin @(negedge Clk); t++; end
        if (!LoadB) check("load_timeout", 0, 1);
        check("winner", {Grant1, Grant0}, (c == 0) ? 2'b01 : 2'b10);
        if (chk_gap) check("idle_gap", cyc - done_cyc, 2);
        t = 0;
        while (!(Done0 | Done1) && t < 40) begin @(negedge Clk); t++; end
        if (!(Done0 | Done1)) check("done_timeout", 0, 1);
        check("done_who", {Done1, Done0}, (c == 0) ? 2'b01 : 2'b10);
        check("product", Product, prod);
        done_cyc = cyc;
    endtask

    task automatic pulse_reset();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        int t;
        int nd;
        Reset = 1'b1;
        Req0 = 1'b0; Req1 = 1'b0;
        Mcand0 = '0; Mcand1 = '0; Mplier0 = '0; Mplier1 = '0;
        #12;
        check("rst_grant", {Grant1, Grant0}, 0);
        check("rst_done", {Done1, Done0}, 0);
        check("rst_product", Product, 0);
        check("rst_strobes", {LoadB, Add, Sub, Fn, Shift}, 0);
        check("rst_operands", {McandOut, MplierOut}, 0);
        @(negedge Clk);
        Reset = 1'b0;

        do_op(0, 8'd7, 8'hFD, 16'hFFEB, 3);
        do_op(1, 8'h80, 8'h80, 16'h4000, 1);
        do_op(1, 8'h55, 8'h00, 16'h0000, 0);

        // Simultaneous requests straight after reset: pointer starts at client 0.
        pulse_reset();
        Req0 = 1'b1; Mcand0 = 8'd3;   Mplier0 = 8'd5;
        Req1 = 1'b1; Mcand1 = 8'hFE;  Mplier1 = 8'd6;
        serve(0, 16'h000F, 1'b0);
        serve(1, 16'hFFF4, 1'b1);
        serve(0, 16'h000F, 1'b1);
        Req0 = 1'b0; Req1 = 1'b0;
        repeat (3) @(negedge Clk);

        // Client 0 alone, request held: back-to-back products.
        Req0 = 1'b1; Mcand0 = 8'd3; Mplier0 = 8'd5;
        serve(0, 16'h000F, 1'b0);
        serve(0, 16'h000F, 1'b1);
        Req0 = 1'b0;
        repeat (3) @(negedge Clk);

        // Reset in cycle 10 of an operation.
        Req0 = 1'b1; Mcand0 = 8'd7; Mplier0 = 8'hFD;
        t = 0;
        while (!LoadB && t < 40) begin @(negedge Clk); t++; end
        if (!LoadB) check("load_timeout", 0, 1);
        repeat (9) @(negedge Clk);
        nd = ndone;
        Reset = 1'b1;
        #1;
        check("abort_grant", {Grant1, Grant0}, 0);
        check("abort_done", {Done1, Done0}, 0);
        check("abort_product", Product, 0);
        check("abort_strobes", {LoadB, Add, Sub, Fn, Shift}, 0);
        check("abort_operands", {McandOut, MplierOut}, 0);
        Req0 = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        repeat (25) @(negedge Clk);
        check("abort_no_done", ndone, nd);
        do_op(0, 8'd2, 8'd2, 16'h0004, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
